// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : loader_pkg
// Description : Shared types and helpers for the program loader: the frame
//               state encoding, the default sync byte and the LEN decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package loader_pkg;

  typedef enum logic [2:0] {
    ST_SYNC  = 3'd0,
    ST_LEN   = 3'd1,
    ST_DATA  = 3'd2,
    ST_CSUM  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } state_t;

  localparam logic [7:0] DEFAULT_MAGIC = 8'hA5;

  // A LEN byte of zero stands for a full RAM image (2**addr_width bytes).
  function automatic logic [31:0] decode_frame_len(input logic [7:0] len_byte,
                                                   input int addr_width);
    logic [31:0] n;
    if (len_byte == 8'd0) n = 32'd1 << addr_width;
    else                  n = {24'd0, len_byte};
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/loader_timeout.sv
`default_nettype none
// ============================================================================
// Module      : loader_timeout
// Description : Idle-cycle watchdog. Counts consecutive enabled cycles with no
//               clear; expired is high during the TIMEOUT_CYCLES-th such cycle.
// Ports       : clk, reset (sync, active-high), clear (activity this cycle),
//               enable (watchdog armed), expired (limit reached this cycle)
// Revision    : 1.0 - initial release
// ============================================================================
module loader_timeout #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] count;

  // The count holds the number of idle cycles already completed, so the
  // current cycle is the limiting one when count reaches TIMEOUT_CYCLES-1.
  assign expired = enable && !clear && (count == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || clear || !enable) begin
      count <= '0;
    end else if (!expired) begin
      count <= count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module      : program_loader
// Description : Receives a framed byte stream (MAGIC, LEN, payload, CSUM) and
//               drives the core's RAM-load port, releasing the core with run
//               once the checksum verifies.
// Ports       : clk, reset        - clock, synchronous active-high reset
//               in_data/in_valid  - stream byte and its qualifier
//               in_ready          - loader accepts a byte this cycle
//               ramAddress/ramIn  - RAM load address/data to the core
//               run               - core release, sticky until reset
//               busy              - frame in progress (LEN/DATA/CSUM)
//               error             - checksum or timeout failure, sticky
//               loaded_count      - payload bytes written in this/last frame
// Revision    : 1.0 - initial release
// ============================================================================
module program_loader
  import loader_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 8,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR     = '0,
  parameter logic [7:0]            MAGIC          = DEFAULT_MAGIC,
  parameter int                    TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] ramAddress,
  output logic [7:0]            ramIn,
  output logic                  run,
  output logic                  busy,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   loaded_count
);

  // remaining must hold both 2**ADDR_WIDTH and any 8-bit LEN value.
  localparam int REM_W = (ADDR_WIDTH + 1 > 9) ? ADDR_WIDTH + 1 : 9;
  localparam logic [ADDR_WIDTH:0] LOAD_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t           state;
  state_t           state_next;
  logic [REM_W-1:0] remaining;
  logic [REM_W-1:0] remaining_init;
  logic [7:0]       sum;
  logic [7:0]       csum_total;
  logic             xfer;
  logic             last_byte;
  logic             timed_out;

  assign xfer           = in_valid & in_ready;
  assign remaining_init = REM_W'(decode_frame_len(in_data, ADDR_WIDTH));
  assign last_byte      = (remaining == REM_W'(1));
  assign csum_total     = sum + in_data;

  loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (xfer),
    .enable (busy),
    .expired(timed_out)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_SYNC;
    else       state <= state_next;
  end

  // in_ready is a pure function of state, so the per-state branches test
  // in_valid directly: in every accepting state that equals a transfer.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    run        = 1'b0;
    error      = 1'b0;
    case (state)
      ST_SYNC: begin
        in_ready = 1'b1;
        if (in_valid && in_data == MAGIC) state_next = ST_LEN;
      end
      ST_LEN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid)       state_next = ST_DATA;
        else if (timed_out) state_next = ST_ERROR;
      end
      ST_DATA: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          if (last_byte) state_next = ST_CSUM;
        end else if (timed_out) begin
          state_next = ST_ERROR;
        end
      end
      ST_CSUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid)       state_next = (csum_total == 8'd0) ? ST_DONE : ST_ERROR;
        else if (timed_out) state_next = ST_ERROR;
      end
      ST_DONE:  run   = 1'b1;
      ST_ERROR: error = 1'b1;
      default:  state_next = ST_SYNC;
    endcase
  end

  // The core rewrites ram[ramAddress] every cycle until run, so the load
  // pair only moves on payload transfers and is held otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      ramAddress   <= START_ADDR;
      ramIn        <= 8'd0;
      loaded_count <= '0;
      sum          <= 8'd0;
      remaining    <= '0;
    end else if (xfer) begin
      case (state)
        ST_SYNC: sum <= 8'd0;
        ST_LEN: begin
          remaining    <= remaining_init;
          sum          <= csum_total;
          loaded_count <= '0;
        end
        ST_DATA: begin
          ramIn      <= in_data;
          ramAddress <= START_ADDR + loaded_count[ADDR_WIDTH-1:0];
          if (loaded_count != LOAD_MAX) loaded_count <= loaded_count + 1'b1;
          sum        <= csum_total;
          remaining  <= remaining - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_loader
// Description : Self-checking bench for program_loader. A frame-level model
//               predicts run/error/count and RAM contents; a core stand-in
//               captures RAM writes from the load port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_loader;

  localparam int         AW    = 8;
  localparam int         CAP   = 256;
  localparam logic [7:0] MAGIC = 8'hA5;
  localparam int         TO    = 1024;
  localparam int         START = 0;

  typedef logic [7:0] bq_t[$];

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    in_data = 8'd0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [AW-1:0] ramAddress;
  logic [7:0]    ramIn;
  logic          run;
  logic          busy;
  logic          error;
  logic [AW:0]   loaded_count;

  int tests = 0;
  int fails = 0;

  logic [7:0] core_ram    [CAP];
  logic [7:0] exp_ram     [CAP];
  bit         exp_written [CAP];
  bit         exp_run;
  bit         exp_err;
  int         exp_cnt;

  always #5 clk = ~clk;

  program_loader dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .ramAddress  (ramAddress),
    .ramIn       (ramIn),
    .run         (run),
    .busy        (busy),
    .error       (error),
    .loaded_count(loaded_count)
  );

  // Core side of the load port: writes every cycle while held in reset-run.
  always @(posedge clk) if (!run) core_ram[ramAddress] <= ramIn;

  // ---------------- reference model (frame level) ----------------
  function automatic void model(input bq_t s);
    int i;
    int n;
    logic [7:0] sum;
    exp_run = 1'b0;
    exp_err = 1'b0;
    exp_cnt = 0;
    for (int k = 0; k < CAP; k++) exp_written[k] = 1'b0;
    i = 0;
    while (i < s.size() && s[i] != MAGIC) i++;
    if (i + 2 >= s.size()) return;
    n   = (s[i+1] == 8'd0) ? CAP : int'(s[i+1]);
    sum = s[i+1];
    for (int k = 0; k < n; k++) begin
      exp_ram[(START + k) % CAP]     = s[i+2+k];
      exp_written[(START + k) % CAP] = 1'b1;
      sum += s[i+2+k];
    end
    exp_cnt = n;
    if (8'(sum + s[i+2+n]) == 8'd0) exp_run = 1'b1;
    else                            exp_err = 1'b1;
  endfunction

  function automatic bq_t make_frame(input bq_t pl, input bit good);
    bq_t f;
    logic [7:0] s;
    logic [7:0] len;
    len = 8'(pl.size());
    s   = len;
    foreach (pl[k]) s += pl[k];
    f.push_back(MAGIC);
    f.push_back(len);
    foreach (pl[k]) f.push_back(pl[k]);
    f.push_back(good ? 8'(8'd0 - s) : 8'(8'd1 - s));
    return f;
  endfunction

  // ---------------- stimulus primitives ----------------
  task automatic idle_cycles(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic play(input bq_t s, input int maxgap);
    foreach (s[k]) begin
      idle_cycles(int'($urandom_range(0, maxgap)));
      send_byte(s[k]);
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    tests++;
    if ({ramAddress, ramIn, run, busy, error, loaded_count, in_ready} !==
        {8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 9'd0, 1'b1}) begin
      fails++;
      $display("FAIL reset_state: got addr=%h data=%h run=%b busy=%b err=%b cnt=%0d rdy=%b want 00 00 0 0 0 0 1",
               ramAddress, ramIn, run, busy, error, loaded_count, in_ready);
    end
  endtask

  task automatic test_valid_frame();
    bq_t pl;
    bq_t f;
    do_reset();
    pl = '{8'h11, 8'h22, 8'h33};
    f  = make_frame(pl, 1'b1);
    model(f);
    send_byte(f[0]);
    send_byte(f[1]);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL t1_busy: got %b want 1", busy);
    end
    for (int k = 0; k < 3; k++) begin
      send_byte(f[2+k]);
      tests++;
      if ({ramAddress, ramIn} !== {8'(START + k), pl[k]}) begin
        fails++;
        $display("FAIL t1_latency[%0d]: got %h/%h want %h/%h", k, ramAddress, ramIn, 8'(START + k), pl[k]);
      end
    end
    send_byte(f[5]);
    tests++;
    if ({run, error, in_ready, busy, loaded_count} !== {exp_run, exp_err, 1'b0, 1'b0, 9'(exp_cnt)}) begin
      fails++;
      $display("FAIL t1_status: got run=%b err=%b rdy=%b busy=%b cnt=%0d want %b %b 0 0 %0d",
               run, error, in_ready, busy, loaded_count, exp_run, exp_err, exp_cnt);
    end
    for (int a = 0; a < CAP; a++) if (exp_written[a]) begin
      tests++;
      if (core_ram[a] !== exp_ram[a]) begin
        fails++;
        $display("FAIL t1_ram[%0d]: got %h want %h", a, core_ram[a], exp_ram[a]);
      end
    end
    // Bytes offered after completion must not be consumed.
    for (int k = 0; k < 3; k++) send_byte(8'($urandom));
    tests++;
    if ({run, error, ramAddress, ramIn, loaded_count} !== {1'b1, 1'b0, 8'h02, 8'h33, 9'd3}) begin
      fails++;
      $display("FAIL t1_hold: got run=%b err=%b addr=%h data=%h cnt=%0d want 1 0 02 33 3",
               run, error, ramAddress, ramIn, loaded_count);
    end
  endtask

  task automatic test_bad_checksum();
    bq_t f;
    do_reset();
    f = make_frame('{8'h11, 8'h22, 8'h33}, 1'b0);
    model(f);
    play(f, 2);
    tests++;
    if ({run, error, in_ready, busy, loaded_count} !== {exp_run, exp_err, 1'b0, 1'b0, 9'(exp_cnt)}) begin
      fails++;
      $display("FAIL t2_status: got run=%b err=%b rdy=%b busy=%b cnt=%0d want %b %b 0 0 %0d",
               run, error, in_ready, busy, loaded_count, exp_run, exp_err, exp_cnt);
    end
    for (int a = 0; a < CAP; a++) if (exp_written[a]) begin
      tests++;
      if (core_ram[a] !== exp_ram[a]) begin
        fails++;
        $display("FAIL t2_ram[%0d]: got %h want %h", a, core_ram[a], exp_ram[a]);
      end
    end
  endtask

  task automatic test_garbage();
    bq_t f;
    bq_t s;
    do_reset();
    f = make_frame('{8'($urandom_range(1, 255))}, 1'b1);
    s = '{8'h00, 8'hFF, 8'h5A};
    foreach (f[k]) s.push_back(f[k]);
    model(s);
    play(s, 1);
    tests++;
    if ({run, error, loaded_count} !== {exp_run, exp_err, 9'(exp_cnt)}) begin
      fails++;
      $display("FAIL t3_status: got run=%b err=%b cnt=%0d want %b %b %0d",
               run, error, loaded_count, exp_run, exp_err, exp_cnt);
    end
    tests++;
    if (core_ram[START] !== exp_ram[START]) begin
      fails++;
      $display("FAIL t3_ram0: got %h want %h", core_ram[START], exp_ram[START]);
    end
  endtask

  task automatic test_full_length();
    bq_t pl;
    bq_t f;
    int bad;
    do_reset();
    for (int k = 0; k < CAP; k++) pl.push_back(8'(k));
    f = make_frame(pl, 1'b1);
    model(f);
    play(f, 0);
    tests++;
    if ({run, error, loaded_count, ramAddress} !== {exp_run, exp_err, 9'(exp_cnt), 8'hFF}) begin
      fails++;
      $display("FAIL t4_status: got run=%b err=%b cnt=%0d addr=%h want %b %b %0d ff",
               run, error, loaded_count, ramAddress, exp_run, exp_err, exp_cnt);
    end
    bad = 0;
    for (int a = 0; a < CAP; a++) if (exp_written[a]) begin
      tests++;
      if (core_ram[a] !== exp_ram[a]) begin
        fails++;
        if (bad < 4) $display("FAIL t4_ram[%0d]: got %h want %h", a, core_ram[a], exp_ram[a]);
        bad++;
      end
    end
  endtask

  task automatic test_timeout();
    bq_t f;
    f = make_frame('{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)}, 1'b1);
    // Stall one cycle short of the limit: frame must still complete.
    do_reset();
    model(f);
    for (int k = 0; k < 4; k++) send_byte(f[k]);
    idle_cycles(TO - 1);
    tests++;
    if ({error, busy} !== 2'b01) begin
      fails++;
      $display("FAIL t5_short_stall: got err=%b busy=%b want 0 1", error, busy);
    end
    for (int k = 4; k < f.size(); k++) send_byte(f[k]);
    tests++;
    if ({run, error, loaded_count} !== {exp_run, exp_err, 9'(exp_cnt)}) begin
      fails++;
      $display("FAIL t5_completes: got run=%b err=%b cnt=%0d want %b %b %0d",
               run, error, loaded_count, exp_run, exp_err, exp_cnt);
    end
    // Full-length stall: error appears exactly after the limiting idle cycle.
    do_reset();
    for (int k = 0; k < 4; k++) send_byte(f[k]);
    idle_cycles(TO - 1);
    tests++;
    if (error !== 1'b0) begin
      fails++;
      $display("FAIL t5_early_error: got %b want 0", error);
    end
    idle_cycles(1);
    tests++;
    if ({error, run, in_ready, busy} !== 4'b1000) begin
      fails++;
      $display("FAIL t5_timeout: got err=%b run=%b rdy=%b busy=%b want 1 0 0 0", error, run, in_ready, busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    bq_t pl;
    bq_t f;
    do_reset();
    send_byte(MAGIC);
    send_byte(8'd5);
    send_byte(8'($urandom));
    send_byte(8'($urandom));
    reset = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if ({ramAddress, ramIn, run, busy, error, loaded_count, in_ready} !==
        {8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 9'd0, 1'b1}) begin
      fails++;
      $display("FAIL t6_abort: got addr=%h data=%h run=%b busy=%b err=%b cnt=%0d rdy=%b want 00 00 0 0 0 0 1",
               ramAddress, ramIn, run, busy, error, loaded_count, in_ready);
    end
    reset = 1'b0;
    for (int k = 0; k < 7; k++) pl.push_back(8'($urandom));
    f = make_frame(pl, 1'b1);
    model(f);
    play(f, 5);
    tests++;
    if ({run, error, loaded_count} !== {exp_run, exp_err, 9'(exp_cnt)}) begin
      fails++;
      $display("FAIL t6_reload: got run=%b err=%b cnt=%0d want %b %b %0d",
               run, error, loaded_count, exp_run, exp_err, exp_cnt);
    end
    for (int a = 0; a < CAP; a++) if (exp_written[a]) begin
      tests++;
      if (core_ram[a] !== exp_ram[a]) begin
        fails++;
        $display("FAIL t6_ram[%0d]: got %h want %h", a, core_ram[a], exp_ram[a]);
      end
    end
  endtask

  task automatic test_random_frames();
    for (int r = 0; r < 4; r++) begin
      bq_t pl;
      bq_t f;
      bq_t s;
      logic [7:0] g;
      do_reset();
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
        g = 8'($urandom);
        if (g == MAGIC) g = 8'h00;
        s.push_back(g);
      end
      for (int k = 0; k < int'($urandom_range(1, 40)); k++) pl.push_back(8'($urandom));
      f = make_frame(pl, (r % 3) != 2);
      foreach (f[k]) s.push_back(f[k]);
      model(s);
      play(s, 4);
      tests++;
      if ({run, error, loaded_count} !== {exp_run, exp_err, 9'(exp_cnt)}) begin
        fails++;
        $display("FAIL rnd%0d_status: got run=%b err=%b cnt=%0d want %b %b %0d",
                 r, run, error, loaded_count, exp_run, exp_err, exp_cnt);
      end
      for (int a = 0; a < CAP; a++) if (exp_written[a]) begin
        tests++;
        if (core_ram[a] !== exp_ram[a]) begin
          fails++;
          $display("FAIL rnd%0d_ram[%0d]: got %h want %h", r, a, core_ram[a], exp_ram[a]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_bad_checksum();
    test_garbage();
    test_full_length();
    test_timeout();
    test_reset_mid_frame();
    test_random_frames();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
